// File: rtl/combo_stim_capture.sv
// combo_stim_capture: on-chip stimulus source and response sink for the
// a/b/c/d -> f datapath. Sweeps all 16 input vectors, holds each for
// HOLD_CYCLES cycles, samples f once per vector, counts ones and folds the
// samples into a MISR signature.
// Optional build macro: COMBO_STIM_GRAY_SEQ_EN (drive vectors in Gray order).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | stimulus parked at 0, results held, waiting for start
// APPLY  | driving vector(vec_idx), hold counter running
// SAMPLE | vector still driven, f captured into ones_cnt / signature
// DONE   | one-cycle done pulse, then back to IDLE
module combo_stim_capture #(
  parameter int                 HOLD_CYCLES = 2,
  parameter int                 SIG_W       = 16,
  parameter logic [SIG_W-1:0]   POLY        = 16'h1021
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             f,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic [3:0]       vec_idx,
  output logic [4:0]       ones_cnt,
  output logic [SIG_W-1:0] signature
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_t;

  localparam logic [7:0] HC_LAST = 8'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       vec_q, vec_d;
  logic [4:0]       ones_q, ones_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [3:0]       abcd_q, abcd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Index-to-vector mapping; vec_idx always counts in binary.
  function automatic logic [3:0] vec_of(input logic [3:0] idx);
`ifdef COMBO_STIM_GRAY_SEQ_EN
    return idx ^ (idx >> 1);
`else
    return idx;
`endif
  endfunction

  // Next-state, counters and result update; outputs derived from next state
  // so every output is registered alongside the state it belongs to.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    vec_d   = vec_q;
    ones_d  = ones_q;
    sig_d   = sig_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          hold_d  = '0;
          vec_d   = '0;
          ones_d  = '0;
          sig_d   = '0;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        hold_d = hold_q + 8'd1;
        if (hold_q == HC_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        ones_d = ones_q + 5'(f);
        sig_d  = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? POLY : '0)
               ^ {{(SIG_W-1){1'b0}}, f};
        if (vec_q == 4'd15) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 4'd1;
          hold_d  = '0;
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_APPLY) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
    abcd_d = busy_d ? vec_of(vec_d) : 4'd0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      vec_q   <= '0;
      ones_q  <= '0;
      sig_q   <= '0;
      abcd_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      ones_q  <= ones_d;
      sig_q   <= sig_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {a, b, c, d} = abcd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign vec_idx      = vec_q;
  assign ones_cnt     = ones_q;
  assign signature    = sig_q;

endmodule
